// File: rtl/temp_pkg.sv
// Shared constants and temperature word type for the thermal front end.
// Defaults are also used by the fan controller bench room model.
package temp_pkg;

    localparam int TEMP_W      = 9;
    localparam int T_LOW_DEF   = 200;
    localparam int T_HIGH_DEF  = 250;
    localparam int HYST_DEF    = 4;
    localparam int DEB_DEF     = 3;
    localparam int TIMEOUT_DEF = 1000;

    typedef logic [TEMP_W-1:0] temp_t;

endpackage

// File: rtl/temp_thresh_if.sv
// Sample-in / flags-out bundle between the sensor path and temp_thresh.
// master: drives temp/valid, reads t1/t2/fault. slave: the reverse.
interface temp_thresh_if
    import temp_pkg::*;
#(
    parameter int W = TEMP_W
) ();

    logic [W-1:0] temp;
    logic         valid;
    logic         t1;
    logic         t2;
    logic         fault;

    modport master (
        output temp,
        output valid,
        input  t1,
        input  t2,
        input  fault
    );

    modport slave (
        input  temp,
        input  valid,
        output t1,
        output t2,
        output fault
    );

endinterface

// File: rtl/temp_thresh_deb_cmp.sv
// deb_cmp: one threshold comparator with optional hysteresis and a
// debounce counter. Ports: clk, clr, valid, hold (clear count), temp, flag.
module deb_cmp
    import temp_pkg::*;
#(
    parameter int W      = TEMP_W,
    parameter int THRESH = T_LOW_DEF,
    parameter int HYST   = HYST_DEF,
    parameter int DEB    = DEB_DEF
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         valid,
    input  logic         hold,
    input  logic [W-1:0] temp,
    output logic         flag
);

    if (HYST > THRESH) begin : g_bad_hyst
        $error("deb_cmp: HYST must not exceed THRESH");
    end
    if (DEB < 1 || DEB > 15) begin : g_bad_deb
        $error("deb_cmp: DEB must be 1..15");
    end

    localparam logic [W-1:0] TH   = W'(THRESH);
    localparam logic [3:0]   LAST = 4'(DEB - 1);

    logic       raw;
    logic [3:0] cnt;

`ifdef TEMP_THRESH_HYST_EN
    // Release point is a constant, so the band costs only a comparator.
    localparam logic [W-1:0] TH_REL = W'(THRESH - HYST);

    always_comb begin
        raw = flag ? (temp >= TH_REL) : (temp >= TH);
    end
`else
    always_comb begin
        raw = (temp >= TH);
    end
`endif

    // A new sample takes priority over hold so that the sample arriving
    // on the watchdog-clearing edge is still counted.
    always_ff @(posedge clk) begin
        if (clr) begin
            flag <= 1'b0;
            cnt  <= 4'd0;
        end else if (valid) begin
            if (raw == flag) begin
                cnt <= 4'd0;
            end else if (cnt == LAST) begin
                flag <= ~flag;
                cnt  <= 4'd0;
            end else begin
                cnt <= cnt + 4'd1;
            end
        end else if (hold) begin
            cnt <= 4'd0;
        end
    end

endmodule

// File: rtl/temp_thresh.sv
// temp_thresh: debounced T1/T2 threshold flags plus sensor watchdog.
// Ports: clk, clr (sync, active-high), bus (temp_thresh_if.slave).
// Optional hysteresis compare: define TEMP_THRESH_HYST_EN.
module temp_thresh
    import temp_pkg::*;
#(
    parameter int W       = TEMP_W,
    parameter int T_LOW   = T_LOW_DEF,
    parameter int T_HIGH  = T_HIGH_DEF,
    parameter int HYST    = HYST_DEF,
    parameter int DEB     = DEB_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic          clk,
    input  logic          clr,
    temp_thresh_if.slave  bus
);

    if (T_LOW >= T_HIGH || T_HIGH >= (1 << W)) begin : g_bad_thr
        $error("temp_thresh: need T_LOW < T_HIGH < 2^W");
    end
    if (TIMEOUT < 2) begin : g_bad_to
        $error("temp_thresh: TIMEOUT must be >= 2");
    end

    localparam int             WDW     = $clog2(TIMEOUT);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

    logic           flag1;
    logic           flag2;
    logic           fault_q;
    logic [WDW-1:0] wd_cnt;

    deb_cmp #(
        .W      (W),
        .THRESH (T_LOW),
        .HYST   (HYST),
        .DEB    (DEB)
    ) u_cmp_t1 (
        .clk   (clk),
        .clr   (clr),
        .valid (bus.valid),
        .hold  (fault_q),
        .temp  (bus.temp),
        .flag  (flag1)
    );

    deb_cmp #(
        .W      (W),
        .THRESH (T_HIGH),
        .HYST   (HYST),
        .DEB    (DEB)
    ) u_cmp_t2 (
        .clk   (clk),
        .clr   (clr),
        .valid (bus.valid),
        .hold  (fault_q),
        .temp  (bus.temp),
        .flag  (flag2)
    );

    // Counter parks at TIMEOUT-1; the next idle edge raises fault.
    always_ff @(posedge clk) begin
        if (clr) begin
            wd_cnt  <= '0;
            fault_q <= 1'b0;
        end else if (bus.valid) begin
            wd_cnt  <= '0;
            fault_q <= 1'b0;
        end else if (wd_cnt == WD_LAST) begin
            fault_q <= 1'b1;
        end else begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    // T2 implies T1 so the fan controller never sees an illegal pair.
    assign bus.t1    = flag1 | flag2 | fault_q;
    assign bus.t2    = flag2 | fault_q;
    assign bus.fault = fault_q;

endmodule

// File: tb/tb_temp_thresh.sv
// Directed bench for temp_thresh: reset, ramp, glitch, hysteresis,
// watchdog and T2-implies-T1 ordering (second instance with DEB=1).
module tb_temp_thresh;
    import temp_pkg::*;

    logic clk;
    logic clr;
    int   checks;
    int   failures;

    temp_thresh_if bus1 ();
    temp_thresh_if bus2 ();

    temp_thresh u_dut (
        .clk (clk),
        .clr (clr),
        .bus (bus1.slave)
    );

    temp_thresh #(
        .DEB (1)
    ) u_dut2 (
        .clk (clk),
        .clr (clr),
        .bus (bus2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One VALID cycle on bus1; returns at the negedge after the sample edge.
    task automatic sample(input int t);
        bus1.temp  = 9'(t);
        bus1.valid = 1'b1;
        @(negedge clk);
        bus1.valid = 1'b0;
    endtask

    task automatic do_reset();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        clr        = 1'b1;
        bus1.temp  = 9'd260;
        bus1.valid = 1'b1;
        bus2.temp  = 9'd0;
        bus2.valid = 1'b0;

        // Reset with a hot sample present: CLR wins.
        @(negedge clk);
        chk("rst1_t1", bus1.t1, 1'b0);
        chk("rst1_t2", bus1.t2, 1'b0);
        chk("rst1_fault", bus1.fault, 1'b0);
        @(negedge clk);
        chk("rst2_t1", bus1.t1, 1'b0);
        chk("rst2_t2", bus1.t2, 1'b0);
        chk("rst2_fault", bus1.fault, 1'b0);
        clr        = 1'b0;
        bus1.valid = 1'b0;
        idle(2);

        // Ramp 190..260, one sample every 4 cycles.
        for (int t = 190; t <= 260; t++) begin
            sample(t);
            chk("ramp_t1", bus1.t1, 1'(t >= 202));
            chk("ramp_t2", bus1.t2, 1'(t >= 252));
            idle(3);
        end

        // Glitch reject: a single cool sample restarts the count.
        do_reset();
        chk("glitch_rst_t2", bus1.t2, 1'b0);
        sample(255);
        chk("glitch_a_t2", bus1.t2, 1'b0);
        sample(255);
        chk("glitch_b_t2", bus1.t2, 1'b0);
        sample(190);
        chk("glitch_c_t2", bus1.t2, 1'b0);
        sample(255);
        sample(255);
        chk("glitch_d_t1", bus1.t1, 1'b0);
        chk("glitch_d_t2", bus1.t2, 1'b0);
        sample(255);
        chk("glitch_e_t1", bus1.t1, 1'b1);
        chk("glitch_e_t2", bus1.t2, 1'b1);

`ifdef TEMP_THRESH_HYST_EN
        // 197 is inside the band for t1 (release below 196).
        for (int i = 1; i <= 3; i++) begin
            sample(197);
            chk("hyst197_t1", bus1.t1, 1'b1);
            chk("hyst197_t2", bus1.t2, 1'(i < 3));
        end
        for (int i = 1; i <= 3; i++) begin
            sample(195);
            chk("hyst195_t1", bus1.t1, 1'(i < 3));
            chk("hyst195_t2", bus1.t2, 1'b0);
        end
`else
        for (int i = 1; i <= 3; i++) begin
            sample(199);
            chk("plain199_t1", bus1.t1, 1'(i < 3));
            chk("plain199_t2", bus1.t2, 1'(i < 3));
        end
`endif

        // Watchdog: set flag1 only, then starve the sensor.
        sample(210);
        sample(210);
        sample(210);
        chk("wd_pre_t1", bus1.t1, 1'b1);
        chk("wd_pre_t2", bus1.t2, 1'b0);
        chk("wd_pre_fault", bus1.fault, 1'b0);
        idle(999);
        chk("wd_999_fault", bus1.fault, 1'b0);
        chk("wd_999_t2", bus1.t2, 1'b0);
        idle(1);
        chk("wd_1000_fault", bus1.fault, 1'b1);
        chk("wd_1000_t1", bus1.t1, 1'b1);
        chk("wd_1000_t2", bus1.t2, 1'b1);
        sample(190);
        chk("wd_clr_fault", bus1.fault, 1'b0);
        chk("wd_clr_t1", bus1.t1, 1'b1);
        chk("wd_clr_t2", bus1.t2, 1'b0);

        // Ordering on the DEB=1 instance (faulted by now; reset clears it).
        do_reset();
        chk("ord_rst_t1", bus2.t1, 1'b0);
        chk("ord_rst_t2", bus2.t2, 1'b0);
        chk("ord_rst_fault", bus2.fault, 1'b0);
        bus2.temp  = 9'd255;
        bus2.valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("ord_burst_t1", bus2.t1, 1'b1);
            chk("ord_burst_t2", bus2.t2, 1'b1);
        end
        bus2.temp = 9'd210;
        @(negedge clk);
        chk("ord_210_t1", bus2.t1, 1'b1);
        chk("ord_210_t2", bus2.t2, 1'b0);
        bus2.temp = 9'd100;
        @(negedge clk);
        chk("ord_100_t1", bus2.t1, 1'b0);
        chk("ord_100_t2", bus2.t2, 1'b0);
        bus2.valid = 1'b0;
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
